// File: rtl/fir4_pkg.sv
// fir4_pkg: shared types, widths and sign-extension helper for the fir4 family
package fir4_pkg;
  localparam int TAPS = 4;
  localparam int W = 16;
  localparam int SW = W + 2;
  localparam int DW = W + 3;
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (i < n) ? v[i] : v[n-1];
    return r;
  endfunction
endpackage

// File: rtl/fir4_hist.sv
// fir4_hist: TAPS-deep w-bit shift register with enable and sync clear; ports clk, reset, en, d in, tap3 = oldest entry out
module fir4_hist import fir4_pkg::*; #(parameter int w = W) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [w-1:0] d,
  output logic [w-1:0] tap3
);
  logic [w-1:0] h [TAPS];
  always_ff @(posedge clk)
    if (reset) h <= '{default: '0};
    else if (en) begin
      for (int i = TAPS - 1; i > 0; i--) h[i] <= h[i-1];
      h[0] <= d;
    end
  assign tap3 = h[TAPS-1];
endmodule

// File: rtl/fir4_inv_u.sv
// fir4_inv_u: rebuilds w-bit samples from a 4-tap moving-sum stream; ports clk, reset, s_in/s_valid in, a_out/a_valid/err/cnt out
module fir4_inv_u import fir4_pkg::*; #(parameter int w = W) (
  input  logic           clk,
  input  logic           reset,
  input  logic [w+1:0]   s_in,
  input  logic           s_valid,
  output logic [w-1:0]   a_out,
  output logic           a_valid,
  output logic           err,
  output logic [7:0]     cnt
);
  localparam int sw = w + 2;
  localparam int dw = w + 3;
  logic [sw-1:0] s_prev;
  logic [w-1:0]  h3;
  logic [dw-1:0] d, x;
  logic          ovf;
  state_t        state, nxt;
  fir4_hist #(.w(w)) u_hist (
    .clk(clk), .reset(reset), .en(s_valid), .d(x[w-1:0]), .tap3(h3)
  );
  always_comb begin
    d = dw'(sext(64'(s_in), sw)) - dw'(sext(64'(s_prev), sw));
    x = d + dw'(sext(64'(h3), w));
    // in range only when every bit above the w-bit sign bit matches it
    ovf = !(&x[dw-1:w-1] || ~|x[dw-1:w-1]);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb nxt = !s_valid ? state : ovf ? ERR : (state == IDLE) ? RUN : state;
  always_comb err = (state == ERR);
  always_ff @(posedge clk)
    if (reset) begin
      s_prev  <= '0;
      a_out   <= '0;
      a_valid <= 1'b0;
      cnt     <= '0;
    end else begin
      a_valid <= s_valid;
      if (s_valid) begin
        s_prev <= s_in;
        a_out  <= x[w-1:0];
        cnt    <= cnt + {7'd0, cnt != 8'hFF};
      end
    end
endmodule

// File: doc/fir4_inv_u.md
Name: fir4_inv_u

Overview:
- Inverse (reconstruction) end of the 4-tap signed moving-sum FIR (fir4_* family, sum s[k] = a[k-1]+a[k-2]+a[k-3]+a[k-4], w+2-bit output).
- Takes the FIR's sum stream and recovers the original w-bit input samples by first-differencing plus a 4-deep recovered-sample history: x[k] = (s[k] - s[k-1]) + x[k-4].
- Used as a loop-back checker and decoder downstream of any FIR topology (tree, cascade, CSA, Wallace). Both the FIR and this block start from all-zero history out of reset.

Parameters:
w  16  sample bit width; sum input is w+2 bits, internal difference is w+3 bits

Ports:
clk        in   1      clock, rising edge
reset      in   1      synchronous, active-high
s_in       in   w+2    signed two's-comp sum sample from FIR
s_valid    in   1      s_in is valid this cycle (accept when high)
a_out      out  w      signed recovered sample
a_valid    out  1      a_out valid (one-cycle pulse per accepted sum)
err        out  1      sticky: reconstruction left w-bit range (desync/corruption)
cnt        out  8      accepted-sample count, saturates at 255

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset: s_prev=0, hist[0..3]=0, a_out=0, a_valid=0, err=0, cnt=0, state=IDLE. Reset has priority over s_valid in the same cycle. Reset mid-stream discards all history; no output is produced for a sum presented in the reset cycle.
- Accept: on rising clk with s_valid=1 and reset=0:
  - d = s_in - s_prev, sign-extended to w+3 bits.
  - x = d + sign-extend(hist[3]), w+3 bits.
  - Registers update: s_prev<=s_in; hist shifts (hist[0]<=x[w-1:0], hist[i]<=hist[i-1]); a_out<=x[w-1:0]; a_valid<=1; cnt<=min(cnt+1,255).
- Latency: exactly 1 clock from accepted s_in to a_out/a_valid.
- s_valid=0: no state change except a_valid<=0; a_out holds its last value. Gaps of any length are transparent.
- Overflow: if x < -2^(w-1) or x > 2^(w-1)-1, then err<=1 in the same cycle a_valid rises for that sample. a_out is still the truncated x[w-1:0] and the history stores the truncated value. err clears only on reset.
- FSM (2-bit):
  - IDLE: no sum accepted since reset.
  - RUN: normal operation.
  - ERR: err set.
  - Transitions: IDLE->RUN on the first accept without overflow; IDLE/RUN->ERR on an overflowing accept; ERR->IDLE only via reset.
  - ERR keeps producing outputs (a_valid pulses continue).
- Arithmetic: all two's complement. The exact s_in range is [-2^(w+1), 2^(w+1)-4]; the block must not assume it. Any 18-bit value (w=16) is legal input.
- Output alignment: for a FIR fed a[0],a[1],..., sum k=1 recovers a[0] and sum k=0 (all-zero taps) recovers 0.

Decomposition:
- Package fir4_pkg:
  - localparam TAPS=4.
  - typedef state_t enum {IDLE,RUN,ERR}.
  - function sext for width extension.
  - Width helpers: SW=w+2, DW=w+3.
- Sub-module fir4_hist: a 4-entry w-bit shift register with enable and synchronous clear, exposing tap[3]. Everything else (differencer, adder, range check, FSM, counter) stays in the top module.

Test Plan:
- Ramp: reset, then s_in=0,1,3,6,10,14 (s_valid=1) -> a_out=0,1,2,3,4,5 one cycle later each, err=0, cnt=6, state RUN.
- Gapped valid: same sums with s_valid low for 3 cycles between each -> identical a_out sequence, a_valid single-cycle pulses, a_out held during gaps.
- Negative extreme: s_in=0,-32768,-65536,-98304,-131072,-131072 -> a_out=0,-32768 x5 (0x8000), err=0.
- Overflow: after reset, s_in=0x1FFFF (131071) -> a_out=0xFFFF (truncated), err=1 with that a_valid, state ERR; later valid sums still pulse a_valid, err stays 1.
- Reset mid-stream: after the ramp to 10, assert reset for 1 cycle with s_valid=1, s_in=14 -> no a_valid, all state zero; then s_in=0,7 -> a_out=0,7.
- FIR loop-back: fir4_wta_u (w=16) driven by 25 $random samples feeds this block -> each a_out equals the input applied 2 accepts earlier, err=0 throughout, cnt=25+.
